// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer between the start push-button and the CPU core:
// debounces start, sequences CPU reset/enable, tracks halt and a cycle watchdog.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_CYCLES    = 2,
  parameter int CNT_W           = 16,
  parameter int MAX_CYCLES      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             cpu_halt,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic             stopped,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RS_W = $clog2(RESET_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RS_W-1:0]  RS_LAST = RS_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
  localparam bit               WD_EN   = (MAX_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BOOT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_STEP   = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              s1_q, s2_q;
  logic              start_db_q, start_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  logic [RS_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              timeout_q, timeout_d;
  logic              cpu_rst_q, cpu_en_q, stopped_q;
  logic              wd_hit;

  // Debounce: start_db follows s2 only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    start_db_d = start_db_q;
    db_cnt_d   = '0;
    if (s2_q != start_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        start_db_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
    press_d = start_db_d & ~start_db_q;
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = '0;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    wd_hit     = WD_EN && (cnt_inc == MAX_C);
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (press_q) begin
          state_d   = ST_BOOT;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_BOOT: begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (boot_cnt_q == RS_LAST) begin
          state_d = step_mode ? ST_PAUSE : ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + RS_W'(1);
        end
      end
      ST_RUN, ST_STEP: begin
        cnt_d = cnt_inc;
        // Halt outranks the watchdog, which outranks a press; STEP always falls back to PAUSE.
        if (cpu_halt) begin
          state_d = ST_HALTED;
        end else if (wd_hit) begin
          state_d   = ST_HALTED;
          timeout_d = 1'b1;
        end else if ((state_q == ST_STEP) || press_q) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (press_q) begin
          state_d = step_mode ? ST_STEP : ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Synchronizer, debounce, FSM and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      start_db_q <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      state_q    <= ST_IDLE;
      boot_cnt_q <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      cpu_rst_q  <= 1'b1;
      cpu_en_q   <= 1'b0;
      stopped_q  <= 1'b1;
    end else begin
      s1_q       <= start;
      s2_q       <= s1_q;
      start_db_q <= start_db_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      cpu_rst_q  <= (state_d == ST_IDLE) || (state_d == ST_BOOT);
      cpu_en_q   <= (state_d == ST_RUN) || (state_d == ST_STEP);
      stopped_q  <= (state_d == ST_IDLE) || (state_d == ST_HALTED);
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign cpu_en      = cpu_en_q;
  assign stopped     = stopped_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule
